i2c_target_regs: RTL

- I2C target (responder) for the opposite end of the system's I2C master serial pins (sda_in/scl_in/sda_oe/scl_oe).
- Exposes a byte-wide register file to an external I2C controller. The local side writes sensor/status bytes into it and reads back bytes the controller wrote.
- Sits in fabric next to the greenhouse sensor logic and connects to open-drain pad buffers at the top level.

---
 rtl/i2c_target_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 46 ++++
 rtl/i2c_target_regs.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus majority-free glitch filter for one I2C line;
// the filtered level only moves after FILTER_LEN identical samples.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_level;
  logic                  r_rise;
  logic                  r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_hist  <= '1;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if ((&r_hist) && !r_level) begin
        r_level <= 1'b1;
        r_rise  <= 1'b1;
      end else if (!(|r_hist) && r_level) begin
        r_level <= 1'b0;
        r_fall  <= 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte register file: controller writes via pointer+data,
// reads via snapshot shift register; local side has a write port and comb read.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h42,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned HOLD_CYC   = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             i2c_serial_scl_in,
  input  logic             i2c_serial_sda_in,
  output logic             i2c_serial_sda_oe,
  output logic             i2c_serial_scl_oe,
  input  logic             loc_wr_en,
  input  logic [PTR_W-1:0] loc_wr_addr,
  input  logic [7:0]       loc_wr_data,
  input  logic [PTR_W-1:0] loc_rd_addr,
  output logic [7:0]       loc_rd_data,
  output logic             bus_wr_strobe,
  output logic [PTR_W-1:0] bus_wr_idx,
  output logic             busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_line  (i2c_serial_scl_in),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_line  (i2c_serial_sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  state_t               r_state;
  logic [7:0]           r_shift;
  logic [7:0]           r_tx;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_byte_done;
  logic                 r_rw;
  logic                 r_mack;
  logic [PTR_W-1:0]     r_ptr;
  logic                 r_sda_oe;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic                 r_busy;
  logic                 r_strobe;
  logic [PTR_W-1:0]     r_wr_idx;
  logic [7:0]           r_regs [NUM_REGS];

  logic             w_start;
  logic             w_stop;
  logic             w_bus_we;
  logic             w_sda_want;
  logic [PTR_W-1:0] w_ptr_inc;

  assign w_start   = w_sda_fall && w_scl_lvl;
  assign w_stop    = w_sda_rise && w_scl_lvl;
  assign w_ptr_inc = r_ptr + PTR_W'(1);
  assign w_bus_we  = (r_state == ST_WR_BYTE) && w_scl_fall && r_byte_done
                     && !w_start && !w_stop;

  // SDA level the current state wants once the post-fall hold time expires
  always_comb begin
    w_sda_want = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_WR_ACK: w_sda_want = ~ACK;
      ST_RD_BYTE:             w_sda_want = ~r_tx[7];
      default:                w_sda_want = 1'b0;
    endcase
  end

  // Register file: the bus write is last so it wins a same-index collision
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (loc_wr_en) r_regs[loc_wr_addr] <= loc_wr_data;
      if (w_bus_we)  r_regs[r_ptr]       <= r_shift;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_tx        <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_rw        <= 1'b0;
      r_mack      <= NACK;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_hold_cnt  <= '0;
      r_busy      <= 1'b0;
      r_strobe    <= 1'b0;
      r_wr_idx    <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (w_stop) begin
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_hold_cnt  <= '0;
        r_byte_done <= 1'b0;
      end else if (w_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_hold_cnt  <= '0;
      end else begin
        // SDA only moves HOLD_CYC cycles after SCL fell, and never with SCL high
        if (w_scl_fall) begin
          r_hold_cnt <= HOLD_W'(HOLD_CYC);
        end else if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          if ((r_hold_cnt == HOLD_W'(1)) && !w_scl_lvl) r_sda_oe <= w_sda_want;
        end

        case (r_state)
          ST_ADDR, ST_PTR, ST_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift     <= {r_shift[6:0], w_sda_lvl};
              r_bit_cnt   <= r_bit_cnt + BIT_CNT_W'(1);
              r_byte_done <= (r_bit_cnt == BIT_CNT_W'(7));
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (r_state == ST_ADDR) begin
                if ((r_shift[7:1] == DEV_ADDR) && (r_shift[7:1] != 7'h00)) begin
                  r_state <= ST_ADDR_ACK;
                  r_rw    <= r_shift[0];
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                r_ptr   <= r_shift[PTR_W-1:0];
                r_state <= ST_WR_ACK;
              end else begin
                r_strobe <= 1'b1;
                r_wr_idx <= r_ptr;
                r_ptr    <= w_ptr_inc;
                r_state  <= ST_WR_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_tx    <= r_regs[r_ptr];
                r_state <= ST_RD_BYTE;
              end else begin
                r_state <= ST_PTR;
              end
            end
          end
          ST_WR_ACK: begin
            if (w_scl_fall) r_state <= ST_WR_BYTE;
          end
          ST_RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt   <= r_bit_cnt + BIT_CNT_W'(1);
              r_byte_done <= (r_bit_cnt == BIT_CNT_W'(7));
            end else if (w_scl_fall) begin
              if (r_byte_done) begin
                r_byte_done <= 1'b0;
                r_state     <= ST_RD_ACK;
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda_lvl;
            end else if (w_scl_fall) begin
              if (r_mack == ACK) begin
                r_ptr     <= w_ptr_inc;
                r_tx      <= r_regs[w_ptr_inc];
                r_bit_cnt <= '0;
                r_state   <= ST_RD_BYTE;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_serial_sda_oe = r_sda_oe;
  assign i2c_serial_scl_oe = 1'b0;
  assign loc_rd_data       = r_regs[loc_rd_addr];
  assign bus_wr_strobe     = r_strobe;
  assign bus_wr_idx        = r_wr_idx;
  assign busy              = r_busy;

endmodule
